// File: rtl/mem_wb_stage.sv
// MEM/WB stage: load align/extend, writeback mux, regfile controls, retire/load counters; 1-cycle latency.
// stall holds the stage and the counters, flush inserts a bubble; rst clears everything and takes priority.
module mem_wb_stage #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     MEM_Result,
  input  logic [DATA_W-1:0]     EXE_MEM_Result,
  input  logic [REG_ADDR_W-1:0] EXE_MEM_Dest,
  input  logic                  EXE_MEM_Valid,
  input  logic                  EXE_MEM_RegWrite,
  input  logic                  EXE_MEM_MemToReg,
  input  logic                  EXE_MEM_Byte,
  input  logic                  double,
  input  logic                  EXE_MEM_Signed,
  input  logic                  stall,
  input  logic                  flush,
  output logic [DATA_W-1:0]     WB_Data,
  output logic [REG_ADDR_W-1:0] WB_Dest,
  output logic                  WB_RegWrite,
  output logic                  WB_Valid,
  output logic [CNT_W-1:0]      RetireCount,
  output logic [CNT_W-1:0]      LoadCount
);

  logic [DATA_W-1:0]     load_ext;
  logic [DATA_W-1:0]     wb_data_d, wb_data_q;
  logic [REG_ADDR_W-1:0] wb_dest_d, wb_dest_q;
  logic                  wb_rw_d, wb_rw_q;
  logic                  wb_vld_d, wb_vld_q;
  logic [CNT_W-1:0]      ret_cnt_d, ret_cnt_q;
  logic [CNT_W-1:0]      ld_cnt_d, ld_cnt_q;

  // Byte access wins over double; word is the remaining case.
  always_comb begin
    load_ext = MEM_Result;
    if (EXE_MEM_Byte) begin
      load_ext = {{(DATA_W-8){EXE_MEM_Signed & MEM_Result[7]}}, MEM_Result[7:0]};
    end else if (!double) begin
      load_ext = {{(DATA_W-32){EXE_MEM_Signed & MEM_Result[31]}}, MEM_Result[31:0]};
    end
  end

  always_comb begin
    wb_data_d = wb_data_q;
    wb_dest_d = wb_dest_q;
    wb_rw_d   = wb_rw_q;
    wb_vld_d  = wb_vld_q;
    ret_cnt_d = ret_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    if (flush) begin
      wb_data_d = '0;
      wb_dest_d = '0;
      wb_rw_d   = 1'b0;
      wb_vld_d  = 1'b0;
    end else if (!stall) begin
      wb_data_d = EXE_MEM_MemToReg ? load_ext : EXE_MEM_Result;
      wb_dest_d = EXE_MEM_Dest;
      wb_vld_d  = EXE_MEM_Valid;
      wb_rw_d   = EXE_MEM_Valid & EXE_MEM_RegWrite & (EXE_MEM_Dest != '0);
      // Counters saturate at all-ones instead of wrapping.
      if (EXE_MEM_Valid && ret_cnt_q != {CNT_W{1'b1}}) begin
        ret_cnt_d = ret_cnt_q + CNT_W'(1);
      end
      if (EXE_MEM_Valid && EXE_MEM_MemToReg && ld_cnt_q != {CNT_W{1'b1}}) begin
        ld_cnt_d = ld_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_q <= '0;
      wb_dest_q <= '0;
      wb_rw_q   <= 1'b0;
      wb_vld_q  <= 1'b0;
      ret_cnt_q <= '0;
      ld_cnt_q  <= '0;
    end else begin
      wb_data_q <= wb_data_d;
      wb_dest_q <= wb_dest_d;
      wb_rw_q   <= wb_rw_d;
      wb_vld_q  <= wb_vld_d;
      ret_cnt_q <= ret_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
    end
  end

  assign WB_Data     = wb_data_q;
  assign WB_Dest     = wb_dest_q;
  assign WB_RegWrite = wb_rw_q;
  assign WB_Valid    = wb_vld_q;
  assign RetireCount = ret_cnt_q;
  assign LoadCount   = ld_cnt_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline stage that sits directly downstream of the data memory. It registers the load result and the EXE/MEM ALU result on the rising clock edge. It also:
- aligns and extends the load data for byte, word and double accesses;
- selects the writeback value and produces the register-file write controls;
- keeps retire and load counters for performance observation.

Parameters:
DATA_W, 64, datapath width; the extension rules assume 64.
REG_ADDR_W, 5, width of the destination register index.
CNT_W, 32, width of each performance counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
MEM_Result  input  DATA_W  data-memory read data; updated on the falling edge, so it is stable at the next rising edge.
EXE_MEM_Result  input  DATA_W  ALU result / effective address from EXE/MEM.
EXE_MEM_Dest  input  REG_ADDR_W  destination register index.
EXE_MEM_Valid  input  1  EXE/MEM slot holds a real instruction.
EXE_MEM_RegWrite  input  1  instruction writes the register file.
EXE_MEM_MemToReg  input  1  writeback source: 1 = load data, 0 = ALU result.
EXE_MEM_Byte  input  1  byte access.
double  input  1  64-bit access; ignored when EXE_MEM_Byte = 1.
EXE_MEM_Signed  input  1  sign-extend byte/word loads; 0 = zero-extend.
stall  input  1  hold the stage registers.
flush  input  1  replace the captured instruction with a bubble.
WB_Data  output  DATA_W  registered writeback value.
WB_Dest  output  REG_ADDR_W  registered destination index.
WB_RegWrite  output  1  registered register-file write enable.
WB_Valid  output  1  stage holds a valid instruction.
RetireCount  output  CNT_W  instructions retired.
LoadCount  output  CNT_W  load instructions retired.

Behaviour:
- Reset: on a rising edge with rst = 1, every output register is cleared to 0, regardless of stall or flush.
- Update priority at each rising edge: rst, then flush, then stall, then normal capture.
- Flush:
  - WB_Valid, WB_RegWrite, WB_Data and WB_Dest are all cleared to 0.
  - Counters do not increment.
- Stall:
  - All stage registers and both counters hold their values.
  - WB_RegWrite stays asserted if it was already asserted. The register file must tolerate repeated identical writes.
- Capture:
  - Latency is 1 cycle: outputs reflect the inputs sampled at the capturing edge.
  - WB_Dest is loaded from EXE_MEM_Dest.
  - WB_Valid is loaded from EXE_MEM_Valid.
  - WB_RegWrite = EXE_MEM_Valid AND EXE_MEM_RegWrite AND (EXE_MEM_Dest != 0). Register 0 is never written.
- Load extension (combinational, ahead of the register), used when MEM_Result is selected:
  - Byte: bits 7:0 of MEM_Result. The upper 56 bits are copies of bit 7 when EXE_MEM_Signed = 1, else zero.
  - Word (Byte = 0, double = 0): bits 31:0 of MEM_Result. The upper 32 bits are copies of bit 31 when EXE_MEM_Signed = 1, else zero.
  - Double: all 64 bits unchanged; Signed is ignored.
  - EXE_MEM_Byte = 1 takes precedence over double = 1.
- Writeback mux: WB_Data takes the extended load data when EXE_MEM_MemToReg = 1, otherwise EXE_MEM_Result unmodified.
- Invalid instruction: with EXE_MEM_Valid = 0, WB_Data and WB_Dest are still captured but WB_RegWrite = 0 and WB_Valid = 0.
- RetireCount:
  - +1 on each capture edge with EXE_MEM_Valid = 1.
  - Saturates at all-ones and does not wrap.
- LoadCount:
  - +1 on each capture edge with EXE_MEM_Valid = 1 and EXE_MEM_MemToReg = 1.
  - Saturates at all-ones.
- Simultaneous stall and flush: flush wins and the stage becomes a bubble.
- Reset mid-stall: reset wins and all state clears.
- No internal state machine beyond the stage register. Both counters are free-running apart from rst, stall and flush.

Test Plan:
1. Reset: rst = 1 for 2 cycles with random inputs driven -> all outputs 0. Release rst -> first valid capture appears one edge later.
2. Signed byte load: MEM_Result = 0x0000_0000_0000_0080, Byte = 1, Signed = 1, MemToReg = 1, Dest = 3, RegWrite = 1 -> WB_Data = 0xFFFF_FFFF_FFFF_FF80, WB_Dest = 3, WB_RegWrite = 1. Repeat with Signed = 0 -> WB_Data = 0x80.
3. Word and double loads: MEM_Result = 0x1234_5678_9ABC_DEF0.
   - Word, Signed = 1 -> WB_Data = 0xFFFF_FFFF_9ABC_DEF0.
   - double = 1 -> WB_Data = 0x1234_5678_9ABC_DEF0.
   - Byte = 1 and double = 1 -> WB_Data = 0xFFFF_FFFF_FFFF_FFF0.
4. ALU path and zero register: MemToReg = 0, EXE_MEM_Result = 0x2A, Dest = 0, RegWrite = 1 -> WB_Data = 0x2A, WB_RegWrite = 0, WB_Valid = 1, RetireCount = 1, LoadCount = 0.
5. Stall/flush: capture a valid load, then stall = 1 for 3 cycles while the inputs change -> outputs and counters frozen. Then stall = 1 and flush = 1 together -> WB_Valid = 0, WB_RegWrite = 0, counters unchanged.
6. Counter saturation: CNT_W forced to 4 and 20 consecutive valid loads -> RetireCount and LoadCount stop at 0xF.
